// File: rtl/lsu_arb_pkg.sv
// Shared types and constants for the two-master LSU arbiter.
package lsu_arb_pkg;

  // Default (and maximum) address width carried in lsu_req_t.
  localparam int unsigned LSU_ADDR_W = 32;

  // Master identifiers, also used as bit positions in one-hot grants.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [0:0] {
    IDLE,
    LOAD_WAIT
  } arb_state_e;

  typedef struct packed {
    logic [LSU_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    logic                  wren;
    logic [2:0]            funct3;
  } lsu_req_t;

endpackage

// File: rtl/lsu_arb_if.sv
// One master channel of the LSU arbiter: request fields, grant and load response.
interface lsu_arb_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              wren;
  logic [2:0]        funct3;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, addr, wdata, wren, funct3,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, wdata, wren, funct3,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/lsu_arb_pick.sv
// Combinational winner select between the two masters, one-hot grant out.
// Build option: LSU_ARB_RR_EN selects round-robin, otherwise fixed priority m0 > m1.
module lsu_arb_pick
  import lsu_arb_pkg::*;
(
  input  logic [1:0] req_i,
`ifdef LSU_ARB_RR_EN
  input  logic       last_i,
`endif
  output logic [1:0] gnt_o
);

  // Pick at most one requester.
  always_comb begin
    gnt_o = 2'b00;
`ifdef LSU_ARB_RR_EN
    if (&req_i) begin
      // On contention the master not granted last time wins.
      gnt_o = (last_i == M0) ? 2'b10 : 2'b01;
    end else begin
      gnt_o = req_i;
    end
`else
    if (req_i[M0]) begin
      gnt_o = 2'b01;
    end else if (req_i[M1]) begin
      gnt_o = 2'b10;
    end
`endif
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Two-master arbiter serialising accesses onto a single-port LSU. Stores complete
// in the grant cycle; a load blocks further grants until its data returns after
// LD_LATENCY cycles. Build option: LSU_ARB_RR_EN (round-robin instead of fixed priority).
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int unsigned LD_LATENCY = 1,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  lsu_arb_if.slave          m0,
  lsu_arb_if.slave          m1,
  output logic [ADDR_W-1:0] o_lsu_addr,
  output logic [31:0]       o_st_data,
  output logic              o_lsu_wren,
  output logic [2:0]        o_funct3,
  input  logic [31:0]       i_ld_data,
  output logic              o_busy
);

  localparam int unsigned CNT_W = (LD_LATENCY < 2) ? 1 : $clog2(LD_LATENCY);

  arb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata0_q;
  logic [31:0]       rdata1_q;
`ifdef LSU_ARB_RR_EN
  logic              last_q;
`endif

  logic [1:0] pick_oh;
  logic [1:0] gnt_oh;
  logic       grant;
  logic       ld_done;
  lsu_req_t   sel;

  lsu_arb_pick u_pick (
    .req_i  ({m1.req, m0.req}),
`ifdef LSU_ARB_RR_EN
    .last_i (last_q),
`endif
    .gnt_o  (pick_oh)
  );

  // Grants only in IDLE; reset gating keeps grants low while reset is held.
  always_comb begin
    gnt_oh  = pick_oh & {2{(state_q == IDLE) && i_reset}};
    grant   = |gnt_oh;
    ld_done = (state_q == LOAD_WAIT) && (cnt_q == '0);
    if (gnt_oh[M1]) begin
      sel = '{addr: LSU_ADDR_W'(m1.addr), wdata: m1.wdata, wren: m1.wren, funct3: m1.funct3};
    end else begin
      sel = '{addr: LSU_ADDR_W'(m0.addr), wdata: m0.wdata, wren: m0.wren, funct3: m0.funct3};
    end
  end

  // LSU and master outputs; address/data hold their last driven value between grants.
  always_comb begin
    m0.gnt     = gnt_oh[M0];
    m1.gnt     = gnt_oh[M1];
    m0.rvalid  = ld_done && (id_q == M0);
    m1.rvalid  = ld_done && (id_q == M1);
    m0.rdata   = m0.rvalid ? i_ld_data : rdata0_q;
    m1.rdata   = m1.rvalid ? i_ld_data : rdata1_q;
    o_lsu_addr = grant ? ADDR_W'(sel.addr) : addr_q;
    o_funct3   = grant ? sel.funct3 : funct3_q;
    o_st_data  = grant ? sel.wdata : wdata_q;
    o_lsu_wren = grant && sel.wren;
    o_busy     = (state_q == LOAD_WAIT);
  end

  // Arbitration FSM, load latency counter and held output values.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      id_q     <= M0;
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef LSU_ARB_RR_EN
      last_q   <= M0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            addr_q   <= ADDR_W'(sel.addr);
            funct3_q <= sel.funct3;
            wdata_q  <= sel.wdata;
`ifdef LSU_ARB_RR_EN
            last_q   <= gnt_oh[M1] ? M1 : M0;
`endif
            if (!sel.wren) begin
              state_q <= LOAD_WAIT;
              cnt_q   <= CNT_W'(LD_LATENCY - 1);
              id_q    <= gnt_oh[M1] ? M1 : M0;
            end
          end
        end
        LOAD_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            if (id_q == M0) begin
              rdata0_q <= i_ld_data;
            end else begin
              rdata1_q <= i_ld_data;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Scoreboard bench for lsu_arbiter with LD_LATENCY = 2. Expected grants and load
// responses are queued by the stimulus and popped by a monitor on each falling edge.
module tb_lsu_arbiter;

  localparam int unsigned LAT = 2;

  localparam int K_GNT0 = 0;
  localparam int K_GNT1 = 1;
  localparam int K_RV0  = 2;
  localparam int K_RV1  = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] o_lsu_addr;
  logic [31:0] o_st_data;
  logic        o_lsu_wren;
  logic [2:0]  o_funct3;
  logic [31:0] i_ld_data;
  logic        o_busy;

  int   checks;
  int   errors;
  int   cyc;
  exp_t sb[$];

  lsu_arb_if #(.ADDR_W(32)) m0_if ();
  lsu_arb_if #(.ADDR_W(32)) m1_if ();

  lsu_arbiter #(
    .LD_LATENCY (LAT),
    .ADDR_W     (32)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .m0         (m0_if),
    .m1         (m1_if),
    .o_lsu_addr (o_lsu_addr),
    .o_st_data  (o_st_data),
    .o_lsu_wren (o_lsu_wren),
    .o_funct3   (o_funct3),
    .i_ld_data  (i_ld_data),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [31:0] val);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [31:0] val);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event actual=kind%0d/%h required=none (cycle %0d)", kind, val, cyc);
    end else begin
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.cyc);
      check("event_value", val, e.val);
    end
  endtask

  // Monitor: every grant or load response must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m0_if.gnt)    observe(K_GNT0, o_lsu_addr);
      if (m1_if.gnt)    observe(K_GNT1, o_lsu_addr);
      if (m0_if.rvalid) observe(K_RV0, m0_if.rdata);
      if (m1_if.rvalid) observe(K_RV1, m1_if.rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_m0(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic wren);
    m0_if.req    = req;
    m0_if.addr   = addr;
    m0_if.wdata  = wdata;
    m0_if.wren   = wren;
    m0_if.funct3 = 3'd2;
  endtask

  task automatic drive_m1(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic wren);
    m1_if.req    = req;
    m1_if.addr   = addr;
    m1_if.wdata  = wdata;
    m1_if.wren   = wren;
    m1_if.funct3 = 3'd5;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, o_lsu_addr, 32'h0);
    check({tag, "_st_data"}, o_st_data, 32'h0);
    check({tag, "_wren_funct3_busy"}, {28'h0, o_lsu_wren, o_funct3}, 32'h0);
    check({tag, "_busy"}, {31'h0, o_busy}, 32'h0);
    check({tag, "_gnt_rvalid"}, {28'h0, m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid},
          32'h0);
    check({tag, "_m0_rdata"}, m0_if.rdata, 32'h0);
    check({tag, "_m1_rdata"}, m1_if.rdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int winner;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    i_ld_data = 32'h0;
    drive_m0(1'b0, 32'h0, 32'h0, 1'b0);
    drive_m1(1'b0, 32'h0, 32'h0, 1'b0);

    // Power-on reset values.
    repeat (2) tick();
    sample();
    check_all_zero("por");
    tick();
    rst_n = 1'b1;

    // m0 store: granted and written in the same cycle.
    tick();
    t0 = cyc;
    drive_m0(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    push(K_GNT0, t0, 32'h10);
    sample();
    check("st_wren", {31'h0, o_lsu_wren}, 32'h1);
    check("st_data", o_st_data, 32'hDEAD_BEEF);
    check("st_funct3", {29'h0, o_funct3}, 32'h2);
    tick();
    drive_m0(1'b0, 32'h0, 32'h0, 1'b0);
    sample();
    check("st_wren_after", {31'h0, o_lsu_wren}, 32'h0);
    check("st_addr_hold", o_lsu_addr, 32'h10);

    // m1 load: data returns LAT cycles after grant, only on master 1.
    tick();
    t0 = cyc;
    drive_m1(1'b1, 32'h0000_0020, 32'h0, 1'b0);
    push(K_GNT1, t0, 32'h20);
    push(K_RV1, t0 + LAT, 32'h1234_5678);
    tick();
    drive_m1(1'b0, 32'h0, 32'h0, 1'b0);
    i_ld_data = 32'h1234_5678;
    sample();
    check("ld_busy", {31'h0, o_busy}, 32'h1);
    check("ld_wren", {31'h0, o_lsu_wren}, 32'h0);
    check("ld_addr_held", o_lsu_addr, 32'h20);
    tick();
    tick();
    i_ld_data = 32'hFFFF_FFFF;
    sample();
    check("ld_busy_done", {31'h0, o_busy}, 32'h0);
    check("m1_rdata_hold", m1_if.rdata, 32'h1234_5678);
    check("m0_rdata_untouched", m0_if.rdata, 32'h0);

    // m1 store requested during an m0 load is stalled until the IDLE cycle after rvalid.
    tick();
    t0 = cyc;
    drive_m0(1'b1, 32'h0000_0030, 32'h0, 1'b0);
    i_ld_data = 32'hA5A5_0001;
    push(K_GNT0, t0, 32'h30);
    push(K_RV0, t0 + LAT, 32'hA5A5_0001);
    push(K_GNT1, t0 + LAT + 1, 32'h40);
    tick();
    drive_m0(1'b0, 32'h0, 32'h0, 1'b0);
    drive_m1(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 1'b1);
    repeat (LAT) tick();
    sample();
    check("stalled_st_wren", {31'h0, o_lsu_wren}, 32'h1);
    tick();
    drive_m1(1'b0, 32'h0, 32'h0, 1'b0);

    // Both masters issue back-to-back loads.
    for (int i = 0; i < 3 * (LAT + 1); i++) begin
      tick();
      drive_m0(1'b1, 32'h0000_0100, 32'h0, 1'b0);
      drive_m1(1'b1, 32'h0000_0200, 32'h0, 1'b0);
      i_ld_data = 32'hC0DE_0000 | 32'(cyc);
      if (i % (LAT + 1) == 0) begin
`ifdef LSU_ARB_RR_EN
        winner = (i / (LAT + 1)) % 2;
`else
        winner = 0;
`endif
        push(winner == 0 ? K_GNT0 : K_GNT1, cyc, winner == 0 ? 32'h100 : 32'h200);
        push(winner == 0 ? K_RV0 : K_RV1, cyc + LAT, 32'hC0DE_0000 | 32'(cyc + LAT));
      end
    end
    tick();
    drive_m0(1'b0, 32'h0, 32'h0, 1'b0);
    drive_m1(1'b0, 32'h0, 32'h0, 1'b0);

    // Both masters store for four cycles, then m0 drops and m1 gets through.
    for (int i = 0; i < 4; i++) begin
      tick();
      drive_m0(1'b1, 32'h0000_0050, 32'h5050_5050, 1'b1);
      drive_m1(1'b1, 32'h0000_0060, 32'h6060_6060, 1'b1);
`ifdef LSU_ARB_RR_EN
      winner = (i % 2 == 0) ? 1 : 0;
`else
      winner = 0;
`endif
      push(winner == 0 ? K_GNT0 : K_GNT1, cyc, winner == 0 ? 32'h50 : 32'h60);
      sample();
      check("dual_st_wren", {31'h0, o_lsu_wren}, 32'h1);
    end
    tick();
    drive_m0(1'b0, 32'h0, 32'h0, 1'b0);
    push(K_GNT1, cyc, 32'h60);
    sample();
    check("m1_st_wren", {31'h0, o_lsu_wren}, 32'h1);
    check("m1_st_data", o_st_data, 32'h6060_6060);
    tick();
    drive_m1(1'b0, 32'h0, 32'h0, 1'b0);
    sample();
    check("idle_wren", {31'h0, o_lsu_wren}, 32'h0);

    // Reset in the middle of an outstanding load discards it.
    tick();
    drive_m0(1'b1, 32'h0000_0070, 32'h0, 1'b0);
    i_ld_data = 32'h7777_7777;
    push(K_GNT0, cyc, 32'h70);
    tick();
    drive_m0(1'b0, 32'h0, 32'h0, 1'b0);
    sample();
    check("pre_reset_busy", {31'h0, o_busy}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_load_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (LAT + 3) tick();
    sample();
    check("post_reset_busy", {31'h0, o_busy}, 32'h0);

    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_arbiter.md
Name: lsu_arbiter

Overview:
- Two-master arbiter in front of the single-port lsu.
- Master 0 is the core pipeline; master 1 is a secondary master (debug/DMA loader).
- Serialises all accesses onto one LSU address/data/wren/funct3 set, and returns load data with a fixed latency matching the synchronous dmem read.
- Non-pipelined: at most one load outstanding.

Parameters:
- LD_LATENCY, 1, cycles from load grant to load data valid at i_ld_data (≥1).
- ADDR_W, 32, address width of masters and LSU.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous active-low reset.
- i_m0_req  in  1  master 0 request; held with its fields until o_m0_gnt.
- i_m0_addr  in  ADDR_W  master 0 address.
- i_m0_wdata  in  32  master 0 store data.
- i_m0_wren  in  1  master 0: 1 = store, 0 = load.
- i_m0_funct3  in  3  master 0 access size/sign.
- o_m0_gnt  out  1  master 0 request accepted this cycle.
- o_m0_rvalid  out  1  master 0 load data valid, 1-cycle pulse.
- o_m0_rdata  out  32  master 0 load data.
- i_m1_req, i_m1_addr, i_m1_wdata, i_m1_wren, i_m1_funct3, o_m1_gnt, o_m1_rvalid, o_m1_rdata: same as master 0, for master 1.
- o_lsu_addr  out  ADDR_W  to lsu i_lsu_addr.
- o_st_data  out  32  to lsu i_st_data.
- o_lsu_wren  out  1  to lsu i_lsu_wren.
- o_funct3  out  3  to lsu i_funct3.
- i_ld_data  in  32  from lsu o_ld_data.
- o_busy  out  1  load outstanding.

Behaviour:
- Clocking and reset: one clock i_clk; reset i_reset is asynchronous, active-low.
- Reset values:
  - State = IDLE; latency counter = 0; last-winner = 0.
  - gnt, rvalid, o_lsu_wren, o_busy = 0.
  - o_lsu_addr, o_st_data, o_funct3, rdata = 0.
- States: IDLE, LOAD_WAIT.
- IDLE:
  - Winner is chosen combinationally among requesting masters.
  - Default policy is fixed priority, m0 over m1.
  - Winner's gnt asserts in the same cycle T. LSU outputs mux the winner's fields in cycle T.
  - o_lsu_wren = winner's wren in T only; a store completes in T with no response.
  - If the winner issued a load: latch addr, funct3 and master id; load counter with LD_LATENCY-1; go to LOAD_WAIT.
- LOAD_WAIT:
  - o_lsu_addr and o_funct3 hold the latched values; o_lsu_wren = 0; no grants; o_busy = 1.
  - Counter decrements each cycle.
  - At cycle T+LD_LATENCY (counter = 0), the latched master's rvalid = 1 and its rdata = i_ld_data (combinational pass-through); then return to IDLE.
  - No grant is issued in the rvalid cycle.
  - Load throughput is one per LD_LATENCY+1 cycles; store throughput is one per cycle.
- o_mX_rdata holds its last value when rvalid = 0.
- LSU outputs when IDLE with no request: addr and funct3 hold their last value; wren = 0.
- Simultaneous requests: exactly one gnt per cycle; the loser keeps req asserted and is re-arbitrated in the next IDLE cycle.
- Requests arriving during LOAD_WAIT are stalled (gnt = 0), not dropped.
- Reset mid-load: outstanding load is discarded; no rvalid after reset release.
- A req deasserted before gnt is legal and treated as withdrawn.

Optional Feature:
- Macro: LSU_ARB_RR_EN.
- Defined: round-robin. When both masters request, the master not granted last wins; last-winner register updates on every gnt.
- Undefined: fixed priority, m0 always wins; last-winner register is absent.

Decomposition:
- Shared package lsu_arb_pkg:
  - typedef enum arb_state_e {IDLE, LOAD_WAIT}.
  - typedef struct lsu_req_t {addr, wdata, wren, funct3}.
  - Constants M0 = 0, M1 = 1.
- One sub-module: lsu_arb_pick, the combinational winner select (fixed / round-robin) taking both reqs and last-winner and returning a one-hot grant.

Test Plan:
- Reset: i_reset = 0 mid-LOAD_WAIT (LD_LATENCY = 3) → all outputs 0 at once; no rvalid after release.
- m0 store addr 0x0000_0010, wdata 0xDEAD_BEEF in cycle T → o_m0_gnt = 1, o_lsu_wren = 1, o_lsu_addr = 0x10 in T; next cycle o_lsu_wren = 0.
- m1 load 0x0000_0020 at T (LD_LATENCY = 1), i_ld_data = 0x1234_5678 at T+1 → o_m1_rvalid = 1, o_m1_rdata = 0x1234_5678 at T+1; o_m0_rvalid stays 0.
- Both req loads every cycle, LD_LATENCY = 2:
  - Fixed priority: gnt pattern m0 only; m1 starves; grants 3 cycles apart.
  - With LSU_ARB_RR_EN: gnt alternates m0, m1, m0.
- m1 req raised during an m0 LOAD_WAIT → o_m1_gnt = 0 until the first IDLE cycle after m0 rvalid, then 1.
- Both masters store simultaneously, 4 cycles (fixed priority) → 4 m0 grants, o_lsu_wren high every cycle; m1 granted the cycle after m0 drops req.
